seg_cmd_decoder: RTL and testbench

SEG_CMD_DECODER -- requirements
Module: seg_cmd_decoder

---
 rtl/seg_cmd_decoder_pkg.sv | 41 ++++
 rtl/seg_hex_decoder.sv | 33 +++
 rtl/seg_cmd_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seg_cmd_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_cmd_decoder_pkg.sv
// Shared constants and types for the 7-segment SPI command decoder.
// SEG_BLINK_EN (optional build macro) enables the blink prescaler and BLINK opcode.
package seg_cmd_decoder_pkg;

    // Opcodes
    localparam logic [7:0] OP_HEX    = 8'h10;
    localparam logic [7:0] OP_RAW    = 8'h20;
    localparam logic [7:0] OP_BLINK  = 8'h30;
    localparam logic [7:0] OP_CLEAR  = 8'h40;
    localparam logic [7:0] OP_CLRERR = 8'h50;

    // Segment bit order in seg_out: {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A     = 0;
    localparam int unsigned SEG_B     = 1;
    localparam int unsigned SEG_C     = 2;
    localparam int unsigned SEG_D     = 3;
    localparam int unsigned SEG_E     = 4;
    localparam int unsigned SEG_F     = 5;
    localparam int unsigned SEG_G     = 6;
    localparam int unsigned SEG_DP    = 7;
    localparam int unsigned SEG_NUM_W = 7;
    localparam int unsigned PAT_W     = 8;

    localparam int unsigned RATE_W = 2;
    localparam int unsigned CNT_W  = 4;

    // Command FSM state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ARG  = 1'b1
    } state_t;

    // Status byte returned on the next SPI transfer
    typedef struct packed {
        logic              in_arg;
        logic              err;
        logic [RATE_W-1:0] rate;
        logic [CNT_W-1:0]  count;
    } status_t;

endpackage : seg_cmd_decoder_pkg

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit to 7-segment hex digit decoder, output bits {g..a}.
module seg_hex_decoder
    import seg_cmd_decoder_pkg::*;
(
    input  logic [3:0]           hex,
    output logic [SEG_NUM_W-1:0] seg_c
);

    // Digit lookup (0-9, A, b, C, d, E, F)
    always_comb begin
        seg_c = '0;
        case (hex)
            4'h0: seg_c = 7'h3F;
            4'h1: seg_c = 7'h06;
            4'h2: seg_c = 7'h5B;
            4'h3: seg_c = 7'h4F;
            4'h4: seg_c = 7'h66;
            4'h5: seg_c = 7'h6D;
            4'h6: seg_c = 7'h7D;
            4'h7: seg_c = 7'h07;
            4'h8: seg_c = 7'h7F;
            4'h9: seg_c = 7'h6F;
            4'hA: seg_c = 7'h77;
            4'hB: seg_c = 7'h7C;
            4'hC: seg_c = 7'h39;
            4'hD: seg_c = 7'h5E;
            4'hE: seg_c = 7'h79;
            4'hF: seg_c = 7'h71;
            default: seg_c = '0;
        endcase
    end

endmodule : seg_hex_decoder

// File: rtl/seg_cmd_decoder.sv
// SPI byte command decoder driving a single 7-segment digit with optional blink.
// Build macro SEG_BLINK_EN adds the blink prescaler and the BLINK opcode;
// without it 0x30 is an unknown opcode and the display never blinks.
module seg_cmd_decoder
    import seg_cmd_decoder_pkg::*;
#(
    parameter int unsigned BLINK_DIV_W = 24,
    parameter int unsigned TMO_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] seg_out,
    output logic [7:0] tx_byte,
    output logic       cmd_err
);

    // Blink taps reach down to bit BLINK_DIV_W-3; timeout compare needs two bits
    if (BLINK_DIV_W < 3 || TMO_W < 2) begin : g_param_err
        $error("seg_cmd_decoder: need BLINK_DIV_W >= 3 and TMO_W >= 2");
    end

    // Last idle count before expiry: the idle cycle seeing this value times out
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t              state_q, state_nx;
    logic [7:0]          op_q, op_nx;
    logic [PAT_W-1:0]    pattern_q, pattern_nx;
    logic [RATE_W-1:0]   rate_q, rate_nx;
    logic [TMO_W-1:0]    tmo_q, tmo_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                err_nx;
    logic                err_set;
    logic                err_clr;
    logic                exec;
    logic                blink_off_c;
    logic [SEG_NUM_W-1:0] hex_seg_c;
    status_t             status_nx;
`ifdef SEG_BLINK_EN
    logic [BLINK_DIV_W-1:0] presc_q;
    logic                   presc_clr;
`endif

    seg_hex_decoder u_hex (
        .hex   (rx_data[3:0]),
        .seg_c (hex_seg_c)
    );

    // Next-state: opcode decode in IDLE, argument execute / timeout in ARG
    always_comb begin
        state_nx   = state_q;
        op_nx      = op_q;
        pattern_nx = pattern_q;
        rate_nx    = rate_q;
        tmo_nx     = tmo_q;
        cnt_nx     = cnt_q;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        exec       = 1'b0;
`ifdef SEG_BLINK_EN
        presc_clr  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_HEX, OP_RAW: begin
                            op_nx    = rx_data;
                            state_nx = ST_ARG;
                            tmo_nx   = '0;
                        end
`ifdef SEG_BLINK_EN
                        OP_BLINK: begin
                            op_nx    = rx_data;
                            state_nx = ST_ARG;
                            tmo_nx   = '0;
                        end
`endif
                        OP_CLEAR: begin
                            pattern_nx = '0;
                            rate_nx    = '0;
                            exec       = 1'b1;
                        end
                        OP_CLRERR: begin
                            err_clr = 1'b1;
                            exec    = 1'b1;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            ST_ARG: begin
                if (rx_valid) begin
                    // A byte arriving on the expiry cycle still completes the command
                    case (op_q)
                        OP_HEX: begin
                            pattern_nx[SEG_DP]      = rx_data[7];
                            pattern_nx[SEG_G:SEG_A] = hex_seg_c;
                        end
                        OP_RAW: pattern_nx = rx_data;
`ifdef SEG_BLINK_EN
                        OP_BLINK: begin
                            rate_nx   = rx_data[RATE_W-1:0];
                            presc_clr = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                    exec     = 1'b1;
                    op_nx    = '0;
                    state_nx = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_set  = 1'b1;
                    op_nx    = '0;
                    state_nx = ST_IDLE;
                end else begin
                    tmo_nx = tmo_q + TMO_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (exec) begin
            cnt_nx = cnt_q + CNT_W'(1);
        end

        // Set beats clear when both are requested
        if (err_set) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end else begin
            err_nx = cmd_err;
        end
    end

    // Status byte tracks the state being loaded this cycle
    always_comb begin
        status_nx.in_arg = (state_nx == ST_ARG);
        status_nx.err    = err_nx;
        status_nx.rate   = rate_nx;
        status_nx.count  = cnt_nx;
    end

`ifdef SEG_BLINK_EN
    // Free-running blink prescaler, restarted by a BLINK command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (presc_clr) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + BLINK_DIV_W'(1);
        end
    end

    // Blink phase tap: faster rates use lower prescaler bits
    always_comb begin
        blink_off_c = 1'b0;
        case (rate_q)
            2'd1:    blink_off_c = presc_q[BLINK_DIV_W-1];
            2'd2:    blink_off_c = presc_q[BLINK_DIV_W-2];
            2'd3:    blink_off_c = presc_q[BLINK_DIV_W-3];
            default: blink_off_c = 1'b0;
        endcase
    end
`else
    assign blink_off_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            pattern_q <= '0;
            rate_q    <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            cmd_err   <= 1'b0;
            seg_out   <= '0;
            tx_byte   <= '0;
        end else begin
            state_q   <= state_nx;
            op_q      <= op_nx;
            pattern_q <= pattern_nx;
            rate_q    <= rate_nx;
            tmo_q     <= tmo_nx;
            cnt_q     <= cnt_nx;
            cmd_err   <= err_nx;
            seg_out   <= blink_off_c ? '0 : pattern_q;
            tx_byte   <= status_nx;
        end
    end

endmodule : seg_cmd_decoder

// File: tb/tb_seg_cmd_decoder.sv
// Self-checking bench for seg_cmd_decoder: directed spec vectors plus random
// byte streams compared against a behavioural command-level model.
module tb_seg_cmd_decoder;

    localparam int unsigned DIV_W = 4;
    localparam int unsigned TMO_W = 4;
    localparam int TMO_LIMIT = (1 << TMO_W) - 1;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] seg_out;
    logic [7:0] tx_byte;
    logic       cmd_err;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state (plain integers)
    bit m_in_arg;
    int m_op, m_pat, m_rate, m_presc, m_idle, m_err, m_cnt, m_seg;

    int hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_cmd_decoder #(
        .BLINK_DIV_W (DIV_W),
        .TMO_W       (TMO_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .seg_out  (seg_out),
        .tx_byte  (tx_byte),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_arg = 1'b0;
        m_op = 0; m_pat = 0; m_rate = 0; m_presc = 0;
        m_idle = 0; m_err = 0; m_cnt = 0; m_seg = 0;
    endtask

    // One clock of command-level behaviour
    task automatic model_edge(input bit v, input int d);
        int phase;
        bit takes_arg;
        phase = 0;
        if (m_rate != 0) phase = (m_presc >> (DIV_W - m_rate)) & 1;
        m_seg = (phase != 0) ? 0 : m_pat;
        m_presc = (m_presc + 1) % (1 << DIV_W);
        if (!m_in_arg) begin
            if (v) begin
                takes_arg = (d == 'h10) || (d == 'h20) || (BLINK_EN && d == 'h30);
                if (takes_arg) begin
                    m_in_arg = 1'b1; m_op = d; m_idle = 0;
                end else if (d == 'h40) begin
                    m_pat = 0; m_rate = 0; m_cnt = (m_cnt + 1) % 16;
                end else if (d == 'h50) begin
                    m_err = 0; m_cnt = (m_cnt + 1) % 16;
                end else begin
                    m_err = 1;
                end
            end
        end else if (v) begin
            if (m_op == 'h10) m_pat = ((d >> 7) << 7) | hex_tab[d % 16];
            else if (m_op == 'h20) m_pat = d;
            else begin
                m_rate = d % 4; m_presc = 0;
            end
            m_cnt = (m_cnt + 1) % 16;
            m_in_arg = 1'b0;
        end else begin
            m_idle++;
            if (m_idle == TMO_LIMIT) begin
                m_in_arg = 1'b0; m_err = 1;
            end
        end
    endtask

    function automatic int exp_tx();
        return (int'(m_in_arg) << 7) | (m_err << 6) | (m_rate << 4) | m_cnt;
    endfunction

    // Drive one cycle, advance model, compare all outputs
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(v, int'(d));
        check("seg_out", 32'(seg_out), 32'(m_seg));
        check("tx_byte", 32'(tx_byte), 32'(exp_tx()));
        check("cmd_err", 32'(cmd_err), 32'(m_err));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step(1'b1, 8'($urandom_range(0, 255)));
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    int r;
    int on_cnt;
    int off_cnt;

    initial begin
        // Reset with rx_valid toggling; strobes during reset are ignored
        do_reset(3);
        check("rst_seg", 32'(seg_out), 32'h00);
        check("rst_tx", 32'(tx_byte), 32'h00);

        // Basic HEX: 0x10 0x85 -> ED, count 1
        send(8'h10); send(8'h85); idle(1);
        check("hex_seg", 32'(seg_out), 32'hED);
        check("hex_tx", 32'(tx_byte), 32'h01);

        // RAW then CLEAR
        do_reset(1);
        send(8'h20); send(8'hAA); idle(1);
        check("raw_seg", 32'(seg_out), 32'hAA);
        send(8'h40); idle(1);
        check("clr_seg", 32'(seg_out), 32'h00);
        check("clr_cnt", 32'(tx_byte[3:0]), 32'd2);

        // Unknown opcode, CLRERR, timeout
        do_reset(1);
        send(8'h77);
        check("unk_err", 32'(cmd_err), 32'd1);
        check("unk_tx", 32'(tx_byte), 32'h40);
        send(8'h50);
        check("clrerr", 32'(cmd_err), 32'd0);
        send(8'h10); idle(14);
        check("tmo_pre", 32'(tx_byte[7]), 32'd1);
        idle(1);
        check("tmo_idle", 32'(tx_byte[7]), 32'd0);
        check("tmo_err", 32'(cmd_err), 32'd1);

        // Argument arriving on the expiry cycle wins
        do_reset(1);
        send(8'h10); idle(14); send(8'h03); idle(1);
        check("tmo_win_err", 32'(cmd_err), 32'd0);
        check("tmo_win_seg", 32'(seg_out), 32'h4F);

        // Blink opcode
        do_reset(1);
        send(8'h20); send(8'hFF); send(8'h30);
`ifdef SEG_BLINK_EN
        send(8'h01);
        on_cnt = 0; off_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            if (seg_out == 8'hFF) on_cnt++;
            if (seg_out == 8'h00) off_cnt++;
        end
        check("blink_on", 32'(on_cnt), 32'd16);
        check("blink_off", 32'(off_cnt), 32'd16);
`else
        check("blink_unk_err", 32'(cmd_err), 32'd1);
        idle(3);
        check("blink_unk_seg", 32'(seg_out), 32'hFF);
`endif

        // Reset mid-command discards latched opcode
        do_reset(1);
        send(8'h10); do_reset(1);
        send(8'h20); send(8'h3C); idle(1);
        check("rst_arg_seg", 32'(seg_out), 32'h3C);

        // Count wrap after 16 executed commands
        do_reset(1);
        for (int i = 0; i < 16; i++) send(8'h50);
        check("cnt_wrap", 32'(tx_byte[3:0]), 32'd0);

        // Random byte streams against the model
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset($urandom_range(1, 2));
            end else if (r < 6) begin
                idle($urandom_range(13, 16));
            end else if ($urandom_range(0, 2) == 0) begin
                if (m_in_arg) begin
                    send(8'($urandom_range(0, 255)));
                end else begin
                    case ($urandom_range(0, 6))
                        0: send(8'h10);
                        1: send(8'h20);
                        2: send(8'h30);
                        3: send(8'h40);
                        4: send(8'h50);
                        default: send(8'($urandom_range(0, 255)));
                    endcase
                end
            end else begin
                idle(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_seg_cmd_decoder
